// File: rtl/addsub_serial_pkg.sv
// Shared types and elaboration helpers for the digit-serial adder/subtractor.
// Width parameters stay on the modules; this package only supplies the helpers that use them.
package addsub_serial_pkg;

  localparam int N_DEF = 32;
  localparam int K_DEF = 8;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  // Digit counter width: clog2(N/K), never below one bit so K==N still has a counter.
  function automatic int cnt_width(input int n, input int k);
    int digits;
    digits = n / k;
    return (digits <= 1) ? 1 : $clog2(digits);
  endfunction

  function automatic bit cfg_ok(input int n, input int k);
    return (k >= 1) && (k <= n) && ((n % k) == 0);
  endfunction

endpackage

// File: rtl/addsub_serial_if.sv
// Request/result bundle between the ALU sequencer (master) and the serial add/sub unit (slave).
interface addsub_serial_if
  import addsub_serial_pkg::*;
#(
  parameter int N = N_DEF
) ();

  logic         start;
  logic         sub;
  logic [N-1:0] a;
  logic [N-1:0] b;
  logic         busy;
  logic         done;
  logic [N-1:0] result;
  logic         cout;
  logic         ovf;
  logic         zero;

  modport master (
    output start, sub, a, b,
    input  busy, done, result, cout, ovf, zero
  );

  modport slave (
    input  start, sub, a, b,
    output busy, done, result, cout, ovf, zero
  );

endinterface

// File: rtl/addsub_serial_addk_slice.sv
// Combinational K-bit ripple adder built from a chain of full adders.
module addk_slice #(
  parameter int K = 8
) (
  input  logic [K-1:0] a_i,
  input  logic [K-1:0] b_i,
  input  logic         ci_i,
  output logic [K-1:0] r_o,
  output logic         co_o
);

  logic [K:0] c;

  assign c[0] = ci_i;

  for (genvar i = 0; i < K; i++) begin : g_fa
    fulladder u_fa (
      .a_i  (a_i[i]),
      .b_i  (b_i[i]),
      .ci_i (c[i]),
      .s_o  (r_o[i]),
      .co_o (c[i+1])
    );
  end

  assign co_o = c[K];

endmodule

// File: rtl/fulladder.sv
// One-bit full adder; the building block of the digit slice.
module fulladder (
  input  logic a_i,
  input  logic b_i,
  input  logic ci_i,
  output logic s_o,
  output logic co_o
);

  assign s_o  = a_i ^ b_i ^ ci_i;
  assign co_o = (a_i & b_i) | (ci_i & (a_i ^ b_i));

endmodule

// File: rtl/addsub_serial.sv
// Digit-serial N-bit add/sub: K bits per cycle through one ripple slice, N/K cycles per op.
//   state | meaning
//   IDLE  | waiting for start; result and flags hold the last completed op
//   RUN   | one digit per cycle, carry kept in carry_q between digits
module addsub_serial
  import addsub_serial_pkg::*;
#(
  parameter int N = N_DEF,
  parameter int K = K_DEF
) (
  input logic            clk,
  input logic            rst_n,
  addsub_serial_if.slave bus
);

  localparam int              NDIG = N / K;
  localparam int              CW   = cnt_width(N, K);
  localparam logic [CW-1:0]   LAST = CW'(NDIG - 1);

  if (!cfg_ok(N, K)) begin : g_bad_cfg
    $error("addsub_serial: K must divide N and lie in 1..N");
  end

  state_e         state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           carry_q, carry_d;
  logic [N-1:0]   opa_q, opa_d;
  logic [N-1:0]   opb_q, opb_d;
  logic [N-1:0]   acc_q, acc_d;
  logic [N-1:0]   result_q, result_d;
  logic           done_q, done_d;
  logic           cout_q, cout_d;
  logic           ovf_q, ovf_d;
  logic           zero_q, zero_d;

  logic [K-1:0]   dig_sum;
  logic           dig_co;
  logic [N+K-1:0] acc_wide;
  logic [N-1:0]   acc_next;

  addk_slice #(.K(K)) u_slice (
    .a_i  (opa_q[K-1:0]),
    .b_i  (opb_q[K-1:0]),
    .ci_i (carry_q),
    .r_o  (dig_sum),
    .co_o (dig_co)
  );

  // New digit enters at the top; the concatenate-and-shift form also covers K == N.
  assign acc_wide = {dig_sum, acc_q} >> K;
  assign acc_next = acc_wide[N-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      carry_q  <= 1'b0;
      opa_q    <= '0;
      opb_q    <= '0;
      acc_q    <= '0;
      result_q <= '0;
      done_q   <= 1'b0;
      cout_q   <= 1'b0;
      ovf_q    <= 1'b0;
      zero_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      carry_q  <= carry_d;
      opa_q    <= opa_d;
      opb_q    <= opb_d;
      acc_q    <= acc_d;
      result_q <= result_d;
      done_q   <= done_d;
      cout_q   <= cout_d;
      ovf_q    <= ovf_d;
      zero_q   <= zero_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    carry_d  = carry_q;
    opa_d    = opa_q;
    opb_d    = opb_q;
    acc_d    = acc_q;
    result_d = result_q;
    done_d   = 1'b0;
    cout_d   = cout_q;
    ovf_d    = ovf_q;
    zero_d   = zero_q;

    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          // Subtract as a + ~b + 1: invert B here, inject the +1 as the first carry-in.
          opa_d   = bus.a;
          opb_d   = bus.b ^ {N{bus.sub}};
          carry_d = bus.sub;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        acc_d   = acc_next;
        opa_d   = opa_q >> K;
        opb_d   = opb_q >> K;
        carry_d = dig_co;
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == LAST) begin
          state_d  = IDLE;
          cnt_d    = '0;
          result_d = acc_next;
          cout_d   = dig_co;
          ovf_d    = (opa_q[K-1] == opb_q[K-1]) && (dig_sum[K-1] != opa_q[K-1]);
          zero_d   = (acc_next == '0);
          done_d   = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.busy   = (state_q == RUN);
  assign bus.done   = done_q;
  assign bus.result = result_q;
  assign bus.cout   = cout_q;
  assign bus.ovf    = ovf_q;
  assign bus.zero   = zero_q;

endmodule

// File: tb/tb_addsub_serial.sv
// Self-checking bench for addsub_serial at N=32 with K=8 (directed) and K=1/4/32/8 (random).
module tb_addsub_serial;

  logic        clk;
  logic        rst_n;
  logic        start_r;
  logic        sub_r;
  logic [31:0] a_r;
  logic [31:0] b_r;
  int          sel;

  logic        busy_o, done_o, cout_o, ovf_o, zero_o;
  logic [31:0] result_o;

  int checks;
  int errors;

  addsub_serial_if #(.N(32)) if8  ();
  addsub_serial_if #(.N(32)) if1  ();
  addsub_serial_if #(.N(32)) if4  ();
  addsub_serial_if #(.N(32)) if32 ();

  addsub_serial #(.N(32), .K(8))  dut8  (.clk(clk), .rst_n(rst_n), .bus(if8.slave));
  addsub_serial #(.N(32), .K(1))  dut1  (.clk(clk), .rst_n(rst_n), .bus(if1.slave));
  addsub_serial #(.N(32), .K(4))  dut4  (.clk(clk), .rst_n(rst_n), .bus(if4.slave));
  addsub_serial #(.N(32), .K(32)) dut32 (.clk(clk), .rst_n(rst_n), .bus(if32.slave));

  assign if8.start  = start_r && (sel == 8);
  assign if1.start  = start_r && (sel == 1);
  assign if4.start  = start_r && (sel == 4);
  assign if32.start = start_r && (sel == 32);
  assign if8.sub  = sub_r;  assign if8.a  = a_r;  assign if8.b  = b_r;
  assign if1.sub  = sub_r;  assign if1.a  = a_r;  assign if1.b  = b_r;
  assign if4.sub  = sub_r;  assign if4.a  = a_r;  assign if4.b  = b_r;
  assign if32.sub = sub_r;  assign if32.a = a_r;  assign if32.b = b_r;

  always_comb begin
    busy_o = if8.busy; done_o = if8.done; result_o = if8.result;
    cout_o = if8.cout; ovf_o = if8.ovf;   zero_o = if8.zero;
    case (sel)
      1: begin
        busy_o = if1.busy; done_o = if1.done; result_o = if1.result;
        cout_o = if1.cout; ovf_o = if1.ovf;   zero_o = if1.zero;
      end
      4: begin
        busy_o = if4.busy; done_o = if4.done; result_o = if4.result;
        cout_o = if4.cout; ovf_o = if4.ovf;   zero_o = if4.zero;
      end
      32: begin
        busy_o = if32.busy; done_o = if32.done; result_o = if32.result;
        cout_o = if32.cout; ovf_o = if32.ovf;   zero_o = if32.zero;
      end
      default: ;
    endcase
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        sub;
    logic [31:0] res;
    logic        c;
    logic        v;
    logic        z;
  } vec_t;

  vec_t tbl [9];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: plain integer arithmetic on the operand values.
  function automatic void model(input logic [31:0] a, input logic [31:0] b, input logic s,
                                output logic [31:0] r, output logic c, output logic v,
                                output logic z);
    longint ua, ub, t, sa, sb, sr;
    ua = longint'({32'd0, a});
    ub = longint'({32'd0, b});
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    if (s) begin
      t  = ua - ub;
      c  = (ua >= ub);
      sr = sa - sb;
    end else begin
      t  = ua + ub;
      c  = (t >= 64'sd4294967296);
      sr = sa + sb;
    end
    r = t[31:0];
    v = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
    z = (r == 32'd0);
  endfunction

  // Must be entered right after a falling edge; returns on the falling edge where done is high.
  task automatic do_op(input logic [31:0] a, input logic [31:0] b, input logic s, input int ndig,
                       input logic [31:0] er, input logic ec, input logic ev, input logic ez,
                       input string tag);
    logic [31:0] prev;
    bit          stable;
    int          lat;
    prev   = result_o;
    stable = 1'b1;
    a_r = a; b_r = b; sub_r = s; start_r = 1'b1;
    @(negedge clk);
    start_r = 1'b0;
    lat = 0;
    while (!done_o && lat < ndig + 3) begin
      if (result_o !== prev) stable = 1'b0;
      @(negedge clk);
      lat++;
    end
    check({tag, " latency"}, 64'(lat), 64'(ndig));
    check({tag, " held"}, 64'(stable), 64'd1);
    check({tag, " result"}, 64'(result_o), 64'(er));
    check({tag, " cout"}, 64'(cout_o), 64'(ec));
    check({tag, " ovf"}, 64'(ovf_o), 64'(ev));
    check({tag, " zero"}, 64'(zero_o), 64'(ez));
  endtask

  task automatic rand_op(input int ndig, input string tag);
    logic [31:0] edges [5];
    logic [31:0] a, b, er;
    logic        s, ec, ev, ez;
    edges[0] = 32'h0; edges[1] = 32'h1; edges[2] = 32'h7FFF_FFFF;
    edges[3] = 32'h8000_0000; edges[4] = 32'hFFFF_FFFF;
    a = ($urandom_range(0, 3) == 0) ? edges[$urandom_range(0, 4)] : $urandom;
    b = ($urandom_range(0, 3) == 0) ? edges[$urandom_range(0, 4)] : $urandom;
    s = 1'($urandom_range(0, 1));
    model(a, b, s, er, ec, ev, ez);
    do_op(a, b, s, ndig, er, ec, ev, ez, tag);
  endtask

  initial begin
    int ks [4];
    int busy_cnt;
    int done_seen;

    checks = 0; errors = 0;
    start_r = 1'b0; sub_r = 1'b0; a_r = '0; b_r = '0; sel = 8;

    tbl[0] = '{32'd5,         32'd3,         1'b1, 32'h0000_0002, 1'b1, 1'b0, 1'b0};
    tbl[1] = '{32'h7FFF_FFFF, 32'd1,         1'b0, 32'h8000_0000, 1'b0, 1'b1, 1'b0};
    tbl[2] = '{32'd0,         32'd1,         1'b1, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0};
    tbl[3] = '{32'hFFFF_FFFF, 32'd1,         1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b1};
    tbl[4] = '{32'h8000_0000, 32'd1,         1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0};
    tbl[5] = '{32'd3,         32'd5,         1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0};
    tbl[6] = '{32'd0,         32'd0,         1'b0, 32'h0000_0000, 1'b0, 1'b0, 1'b1};
    tbl[7] = '{32'h8000_0000, 32'h8000_0000, 1'b0, 32'h0000_0000, 1'b1, 1'b1, 1'b1};
    tbl[8] = '{32'd5,         32'd5,         1'b1, 32'h0000_0000, 1'b1, 1'b0, 1'b1};

    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #2;
    ks[0] = 8; ks[1] = 1; ks[2] = 4; ks[3] = 32;
    foreach (ks[i]) begin
      sel = ks[i];
      #1;
      check("reset busy", 64'(busy_o), 64'd0);
      check("reset done", 64'(done_o), 64'd0);
      check("reset result", 64'(result_o), 64'd0);
      check("reset flags", 64'({cout_o, ovf_o, zero_o}), 64'd0);
    end
    sel = 8;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 9; i++)
      do_op(tbl[i].a, tbl[i].b, tbl[i].sub, 4, tbl[i].res, tbl[i].c, tbl[i].v, tbl[i].z,
            $sformatf("vec%0d", i));

    // start held high while busy: only the first op runs
    @(negedge clk);
    a_r = 32'd100; b_r = 32'd23; sub_r = 1'b0; start_r = 1'b1;
    busy_cnt = 0;
    for (int i = 1; i <= 3; i++) begin
      @(negedge clk);
      if (busy_o) busy_cnt++;
      a_r = $urandom; b_r = $urandom; sub_r = 1'b1;
    end
    @(negedge clk);
    if (busy_o) busy_cnt++;
    start_r = 1'b0;
    @(negedge clk);
    check("hold done", 64'(done_o), 64'd1);
    check("hold busy after", 64'(busy_o), 64'd0);
    check("hold busy cycles", 64'(busy_cnt), 64'd4);
    check("hold result", 64'(result_o), 64'd123);
    @(negedge clk);
    check("hold no second op", 64'({busy_o, done_o}), 64'd0);

    // back-to-back: second start lands in the first op's done cycle
    do_op(32'h1000, 32'h1, 1'b0, 4, 32'h1001, 1'b0, 1'b0, 1'b0, "b2b first");
    do_op(32'h2, 32'h3, 1'b1, 4, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0, "b2b second");
    @(negedge clk);
    do_op(32'hFFFF_FFFF, 32'h2, 1'b0, 4, 32'h1, 1'b1, 1'b0, 1'b0, "pre reset");

    // reset in the middle of an operation
    @(negedge clk);
    a_r = 32'h1234_5678; b_r = 32'h1111_1111; sub_r = 1'b0; start_r = 1'b1;
    @(negedge clk);
    start_r = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst busy", 64'(busy_o), 64'd0);
    check("midrst done", 64'(done_o), 64'd0);
    check("midrst result", 64'(result_o), 64'd0);
    check("midrst flags", 64'({cout_o, ovf_o, zero_o}), 64'd0);
    done_seen = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (i == 2) rst_n = 1'b1;
      if (done_o) done_seen++;
    end
    check("midrst no done", 64'(done_seen), 64'd0);
    do_op(32'h1234_5678, 32'h1111_1111, 1'b0, 4, 32'h2345_6789, 1'b0, 1'b0, 1'b0, "after rst");

    sel = 1;
    @(negedge clk);
    for (int i = 0; i < 1000; i++) rand_op(32, "k1");
    sel = 4;
    @(negedge clk);
    for (int i = 0; i < 1000; i++) rand_op(8, "k4");
    sel = 32;
    @(negedge clk);
    for (int i = 0; i < 1000; i++) rand_op(1, "k32");
    sel = 8;
    @(negedge clk);
    for (int i = 0; i < 300; i++) rand_op(4, "k8");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/addsub_serial.md
Name: addsub_serial

Overview:
- Parametrised, digit-serial N-bit adder/subtractor; the multi-cycle successor to the 32-bit ripple subtract datapath.
- Processes K bits per cycle through one K-bit ripple slice, so a full operation takes N/K cycles.
- Supports both add and subtract (two's complement), with start/busy/done handshake and carry/overflow/zero flags.
- Sits in the ALU as the area-lean add/sub path, beside the combinational units.

Parameters:
- N, 32, operand and result width.
- K, 8, digit width processed per cycle; N % K == 0 required, 1 <= K <= N.

Ports:
- clk  input  1  clock, rising-edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request; sampled only when busy==0.
- sub  input  1  0 = a+b, 1 = a-b; latched with start.
- a  input  N  operand A; latched with start.
- b  input  N  operand B; latched with start.
- busy  output  1  high while an operation is in progress.
- done  output  1  one-cycle pulse when result/flags become valid.
- result  output  N  sum/difference; held until the next completion.
- cout  output  1  final carry out; for sub, 1 means no borrow (a >= b unsigned).
- ovf  output  1  signed two's-complement overflow.
- zero  output  1  result == 0.

Behaviour:
- Reset (rst_n low, asynchronous): state IDLE, digit counter 0, carry 0; busy, done, result, cout, ovf and zero all 0.
- States and transitions:
  - IDLE, start==1: latch a into opa and (b XOR {N{sub}}) into opb; carry <= sub; cnt <= 0; -> RUN.
  - IDLE, start==0: stay in IDLE.
  - RUN, each cycle:
    - s = opa[K-1:0] + opb[K-1:0] + carry, giving K+1 bits.
    - acc <= {s[K-1:0], acc[N-1:K]}.
    - opa and opb shift right by K; carry <= s[K]; cnt++.
  - RUN with cnt == N/K-1: finishes the last digit and returns to IDLE.
    - result <= final acc value; cout <= s[K].
    - ovf <= (opa_msb == opb_msb) && (sum_msb != opa_msb), using the last digit's top bits.
    - zero <= (final acc == 0).
    - done <= 1 for exactly one cycle.
- Latency: start sampled at edge E0 -> done high and result valid after edge E(N/K). For N=32, K=8 that is 4 cycles. For K=N it is 1 cycle.
- busy is high exactly while in RUN. It is registered and deasserts on the same edge that raises done.
- start while busy==1 is ignored: no queuing, no effect on the operation in flight.
- start in the done cycle is accepted, since state is IDLE; back-to-back throughput is one result per N/K cycles.
- result and the flags are stable between done pulses. They are not disturbed by a new start until that operation completes.
- Reset mid-operation aborts immediately with no done pulse and all outputs cleared.
- Arithmetic is modulo 2^N. Carry propagates between digits only through the carry register.

Decomposition:
- Shared package or header holds:
  - state encodings IDLE=1'b0 and RUN=1'b1;
  - the digit-count width constant, clog2(N/K) with a minimum of 1;
  - the elaboration check that N % K == 0.
- One sub-module, addk_slice: combinational K-bit ripple adder (a, b, ci -> r[K-1:0], co), built as a generate chain of the existing fulladder.
- Top level holds the FSM, shift registers, counter and flag logic.

Test Plan (N=32, K=8):
- Subtract: sub=1, a=5, b=3 -> done after 4 cycles; result=0x00000002, cout=1, ovf=0, zero=0.
- Add with signed overflow: sub=0, a=0x7FFFFFFF, b=1 -> result=0x80000000, cout=0, ovf=1, zero=0.
- Borrow and wrap: sub=1, a=0, b=1 -> result=0xFFFFFFFF, cout=0, ovf=0. Then add a=0xFFFFFFFF, b=1 -> result=0, cout=1, zero=1, ovf=0.
- Handshake:
  - Pulse start, then hold start high with different operands for cycles 1-3 -> only the first operation runs; busy high for exactly 4 cycles.
  - A start asserted in the done cycle is accepted; its done follows 4 cycles later.
  - result is unchanged until that second done.
- Reset mid-operation: start a=0x12345678, b=0x11111111 add, drop rst_n at cycle 2 -> all outputs 0 immediately; no done. After release, a new op 0x12345678+0x11111111 gives 0x23456789.
- Parameter sweep: K=1, K=4 and K=32, random 1000 ops each against a reference model -> result/cout/ovf/zero match; latency = N/K.
